// File: rtl/spi_master_pingpong_tx.sv
// SPI mode-0 master that streams one ping-pong buffer of 16-bit words,
// MSB first, reading a 1-cycle-latency RAM and capturing miso per word.
module spi_master_pingpong_tx #(
  parameter int CLK_DIV = 4,
  parameter int WORDS   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readyb,
  input  logic [15:0] doutb,
  output logic [6:0]  addrb,
  output logic        finishb,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        ssel,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [6:0]    ADDR_MAX = 7'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_GAP, S_DONE
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_div;
  logic [4:0]      r_bit;
  logic [15:0]     r_tx;
  logic [15:0]     r_rx;
  logic [6:0]      r_addr;
  logic            r_sck;
  logic            r_mosi;
  logic            r_ssel;
  logic [15:0]     r_rx_data;
  logic            r_rx_valid;
  logic            r_finish;
  logic            r_busy;

  assign addrb    = r_addr;
  assign finishb  = r_finish;
  assign sck      = r_sck;
  assign mosi     = r_mosi;
  assign ssel     = r_ssel;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_addr     <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_ssel     <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_finish   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_finish   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (readyb) begin
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_tx    <= doutb;
          r_mosi  <= doutb[15];
          r_ssel  <= 1'b0;
          r_div   <= '0;
          r_bit   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_div == DIV_MAX) begin
            r_div <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
              r_rx  <= {r_rx[14:0], miso};
            end else begin
              r_sck <= 1'b0;
              // falling edge of the 16th bit ends the frame
              if (r_bit == 5'd15) begin
                r_rx_data  <= r_rx;
                r_rx_valid <= 1'b1;
                r_ssel     <= 1'b1;
                r_mosi     <= 1'b0;
                r_bit      <= '0;
                r_state    <= S_GAP;
              end else begin
                r_bit  <= r_bit + 5'd1;
                r_mosi <= r_tx[14];
                r_tx   <= {r_tx[14:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GAP: begin
          if (r_div == DIV_MAX) begin
            r_div <= '0;
            if (r_addr < ADDR_MAX) begin
              r_addr  <= r_addr + 7'd1;
              r_state <= S_FETCH;
            end else begin
              r_addr   <= '0;
              r_finish <= 1'b1;
              r_state  <= S_DONE;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
